// File: rtl/buffer_seq_pkg.sv
// Shared types for the mode-1 buffer sequencer: FSM states, latched job
// descriptor and the per-lane write-back delay entry.
`ifndef N_BUF
`define N_BUF 4
`endif
`ifndef ADDR_RAM
`define ADDR_RAM 8
`endif

package buffer_seq_pkg;

    localparam int unsigned SEQ_N_BUF  = `N_BUF;
    localparam int unsigned SEQ_ADDR_W = `ADDR_RAM;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } seq_state_e;

    typedef struct packed {
        logic [SEQ_ADDR_W-1:0] rd_base;
        logic [SEQ_ADDR_W-1:0] wr_base;
        logic [SEQ_ADDR_W-1:0] length;
        logic [SEQ_N_BUF-1:0]  mask;
        logic                  skew;
    } seq_job_t;

    typedef struct packed {
        logic                  en;
        logic [SEQ_ADDR_W-1:0] idx;
    } lane_entry_t;

endpackage

// File: rtl/lane_delay_line.sv
// Fixed-depth shift register carrying issued-read entries to the write-back
// point; freezes on hold and clears synchronously.
module lane_delay_line #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             hold,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

    always_comb begin
        stage_d = stage_q;
        if (!hold) begin
            stage_d[0] = d_in;
            for (int unsigned s = 1; s < DEPTH; s++) begin
                stage_d[s] = stage_q[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign d_out = stage_q[DEPTH-1];

endmodule

// File: rtl/buffer_m1_sequencer.sv
// Mode-1 initiator: streams consecutive reads out of each enabled buffer and
// writes results back WB_LAT non-stalled cycles later.
module buffer_m1_sequencer
    import buffer_seq_pkg::*;
#(
    parameter int unsigned N_BUF  = SEQ_N_BUF,
    parameter int unsigned ADDR_W = SEQ_ADDR_W,
    parameter int unsigned WB_LAT = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ADDR_W-1:0]              rd_base,
    input  logic [ADDR_W-1:0]              wr_base,
    input  logic [ADDR_W-1:0]              length,
    input  logic [N_BUF-1:0]               buf_mask,
    input  logic                           skew,
    input  logic                           stall,
    output logic                           busy,
    output logic                           done,
    output logic [N_BUF-1:0]               m1_r_en,
    output logic [N_BUF-1:0][ADDR_W-1:0]   m1_r_addr,
    output logic [N_BUF-1:0]               m1_w_en,
    output logic [N_BUF-1:0][ADDR_W-1:0]   m1_w_addr
);

    localparam int unsigned CNT_W = ADDR_W + $clog2(N_BUF) + 2;

    seq_state_e                  state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    seq_job_t                    job_q, job_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        issue;
    logic [CNT_W-1:0]            issue_idx;
    logic [CNT_W-1:0]            run_last;

    logic [N_BUF-1:0]            r_en_q, r_en_d, w_en_q, w_en_d;
    logic [N_BUF-1:0][ADDR_W-1:0] r_addr_q, r_addr_d, w_addr_q, w_addr_d;
    lane_entry_t [N_BUF-1:0]     ent_in, ent_out;

    assign run_last = CNT_W'(job_q.length)
                    + (job_q.skew ? CNT_W'(N_BUF - 1) : '0)
                    - CNT_W'(1);

    // Outputs are precomputed one cycle ahead: issue/issue_idx name the RUN
    // cycle that the registers will present after this edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        job_d     = job_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        issue     = 1'b0;
        issue_idx = '0;
        if (!stall) begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        job_d.rd_base = rd_base;
                        job_d.wr_base = wr_base;
                        job_d.length  = length;
                        job_d.mask    = buf_mask;
                        job_d.skew    = skew;
                        if (length == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = RUN;
                            cnt_d   = '0;
                            busy_d  = 1'b1;
                            issue   = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (cnt_q == run_last) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d     = cnt_q + 1'b1;
                        issue     = 1'b1;
                        issue_idx = cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (cnt_q == CNT_W'(WB_LAT - 1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < N_BUF; i++) begin : g_lane
        localparam logic [CNT_W-1:0] LANE_OFF = CNT_W'(i);
        logic [CNT_W-1:0] off;
        logic [CNT_W-1:0] k;
        logic             hit;

        always_comb begin
            off = job_d.skew ? LANE_OFF : '0;
            k   = issue_idx - off;
            hit = issue && job_d.mask[i] && (issue_idx >= off)
                  && (k < CNT_W'(job_d.length));
        end

        assign ent_in[i].en  = hit;
        assign ent_in[i].idx = hit ? k[ADDR_W-1:0] : '0;

        assign r_en_d[i]   = stall ? r_en_q[i]   : hit;
        assign r_addr_d[i] = stall ? r_addr_q[i]
                           : (hit ? job_d.rd_base + k[ADDR_W-1:0] : '0);
        assign w_en_d[i]   = stall ? w_en_q[i]   : ent_out[i].en;
        assign w_addr_d[i] = stall ? w_addr_q[i]
                           : (ent_out[i].en ? job_q.wr_base + ent_out[i].idx : '0);
    end

    lane_delay_line #(
        .DEPTH(WB_LAT),
        .WIDTH(N_BUF * $bits(lane_entry_t))
    ) u_delay (
        .clk  (clk),
        .clr  (rst),
        .hold (stall),
        .d_in (ent_in),
        .d_out(ent_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            job_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            r_en_q   <= '0;
            r_addr_q <= '0;
            w_en_q   <= '0;
            w_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            job_q    <= job_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            r_en_q   <= r_en_d;
            r_addr_q <= r_addr_d;
            w_en_q   <= w_en_d;
            w_addr_q <= w_addr_d;
        end
    end

    // Held enables must not repeat while stalled, so stall masks them in-cycle.
    assign busy      = busy_q;
    assign done      = done_q;
    assign m1_r_en   = r_en_q & ~{N_BUF{stall}};
    assign m1_r_addr = r_addr_q;
    assign m1_w_en   = w_en_q & ~{N_BUF{stall}};
    assign m1_w_addr = w_addr_q;

endmodule

// File: tb/tb_buffer_m1_sequencer.sv
// Scoreboard bench for buffer_m1_sequencer against a virtual-time job model.
`timescale 1ns/1ps
module tb_buffer_m1_sequencer;

    localparam int NB = 4;
    localparam int AW = 8;
    localparam int WL = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst, start, skew, stall;
    logic [AW-1:0]          rd_base, wr_base, length;
    logic [NB-1:0]          buf_mask;
    logic                   busy, done;
    logic [NB-1:0]          m1_r_en, m1_w_en;
    logic [NB-1:0][AW-1:0]  m1_r_addr, m1_w_addr;

    buffer_m1_sequencer #(
        .N_BUF (NB),
        .ADDR_W(AW),
        .WB_LAT(WL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rd_base  (rd_base),
        .wr_base  (wr_base),
        .length   (length),
        .buf_mask (buf_mask),
        .skew     (skew),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .m1_r_en  (m1_r_en),
        .m1_r_addr(m1_r_addr),
        .m1_w_en  (m1_w_en),
        .m1_w_addr(m1_w_addr)
    );

    typedef struct {
        logic                  busy;
        logic                  done;
        logic [NB-1:0]         r_en;
        logic [NB-1:0]         w_en;
        logic [NB-1:0][AW-1:0] r_addr;
        logic [NB-1:0][AW-1:0] w_addr;
        int unsigned           cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;

    // Job model: v counts non-stalled cycles since accept (v=1 is first RUN cycle)
    bit            m_active = 0;
    bit            m_done   = 0;
    int            m_v = 0, m_rd = 0, m_wr = 0, m_len = 0;
    bit [NB-1:0]   m_mask = '0;
    bit            m_skew = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp,
                       input int unsigned c);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("busy",   64'(busy),      64'(mon_e.busy),   mon_e.cyc);
            chk("done",   64'(done),      64'(mon_e.done),   mon_e.cyc);
            chk("r_en",   64'(m1_r_en),   64'(mon_e.r_en),   mon_e.cyc);
            chk("r_addr", 64'(m1_r_addr), 64'(mon_e.r_addr), mon_e.cyc);
            chk("w_en",   64'(m1_w_en),   64'(mon_e.w_en),   mon_e.cyc);
            chk("w_addr", 64'(m1_w_addr), 64'(mon_e.w_addr), mon_e.cyc);
        end
    end

    task automatic step(input bit st, input bit sl, input bit rs, input int rd, input int wr,
                        input int len, input bit [NB-1:0] mk, input bit sk);
        exp_t e;
        int   s, k;
        start    = st;
        stall    = sl;
        rst      = rs;
        rd_base  = AW'(rd);
        wr_base  = AW'(wr);
        length   = AW'(len);
        buf_mask = mk;
        skew     = sk;
        e.cyc    = cyc;
        e.busy   = 1'b0;
        e.done   = m_done;
        e.r_en   = '0;
        e.w_en   = '0;
        e.r_addr = '0;
        e.w_addr = '0;
        s = m_skew ? NB - 1 : 0;
        if (m_active) begin
            e.busy = 1'b1;
            for (int i = 0; i < NB; i++) begin
                k = m_v - 1 - (m_skew ? i : 0);
                if (m_mask[i] && k >= 0 && k < m_len) begin
                    e.r_en[i]   = !sl;
                    e.r_addr[i] = AW'(m_rd + k);
                end
                k = k - WL;
                if (m_mask[i] && k >= 0 && k < m_len) begin
                    e.w_en[i]   = !sl;
                    e.w_addr[i] = AW'(m_wr + k);
                end
            end
        end
        sb.push_back(e);
        m_done = 0;
        if (rs) begin
            m_active = 0;
        end else if (!sl) begin
            if (m_active) begin
                m_v++;
                if (m_v > m_len + s + WL) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end else if (st) begin
                m_rd = rd; m_wr = wr; m_len = len; m_mask = mk; m_skew = sk;
                if (len == 0) m_done = 1;
                else begin
                    m_active = 1;
                    m_v      = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(0, 0, 0, 0, 0, 0, '0, 0);
    endtask

    // Accept, then run until the model leaves the job; the next step is the done cycle.
    task automatic run_job(input int rd, input int wr, input int len, input bit [NB-1:0] mk,
                           input bit sk, input int sf, input int st_to);
        int rel = 1;
        step(1, 0, 0, rd, wr, len, mk, sk);
        while (m_active && rel < 500) begin
            step(0, (rel >= sf && rel <= st_to), 0, 0, 0, 0, '0, 0);
            rel++;
        end
    endtask

    initial begin
        rst = 1; start = 0; stall = 0; skew = 0;
        rd_base = '0; wr_base = '0; length = '0; buf_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        idle(2);
        run_job(10, 100, 4, 4'b1111, 0, -1, -1);
        idle(2);
        run_job(0, 50, 2, 4'b1010, 1, -1, -1);
        idle(2);
        run_job(10, 100, 4, 4'b1111, 0, 2, 3);
        idle(2);
        run_job(254, 253, 4, 4'b1111, 0, -1, -1);
        idle(1);
        run_job(5, 5, 0, 4'b1111, 0, -1, -1);
        idle(2);
        // reset during DRAIN, with ignored starts while busy
        step(1, 0, 0, 20, 30, 3, 4'b1111, 1);
        while (m_active && m_v <= m_len + NB - 1) step(1, 0, 0, 7, 8, 5, 4'b0011, 0);
        step(0, 0, 1, 0, 0, 0, '0, 0);
        idle(3);
        // back-to-back: second start lands on the done cycle
        run_job(1, 2, 3, 4'b0101, 0, -1, -1);
        run_job(40, 60, 2, 4'b1111, 1, -1, -1);
        idle(2);
        for (int j = 0; j < 60; j++) begin
            int  guard;
            bit  do_rst;
            do_rst = ($urandom_range(0, 9) == 0);
            guard  = 0;
            step(1, 0, 0, $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 6), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            while (m_active && guard < 300) begin
                if (do_rst && $urandom_range(0, 7) == 0) begin
                    step(0, 0, 1, 0, 0, 0, '0, 0);
                    break;
                end
                step(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), 0,
                     $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 6),
                     4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
                guard++;
            end
            idle($urandom_range(0, 2));
        end
        idle(3);
        for (int j = 0; j < 5 && sb.size() > 0; j++) @(posedge clk);
        if (sb.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
